// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cacheline-adaptor port between i_cache (read-only) and d_cache (read/write).
// One transaction per grant, alternating tie-break, plus an i_cache stall-cycle counter.
module mem_port_arbiter #(
   parameter int unsigned s_line = 256,
   parameter int unsigned s_addr = 32,
   parameter int unsigned s_cnt  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pmem_read,
   input  logic [s_addr-1:0] i_pmem_address,
   output logic [s_line-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [s_addr-1:0] d_pmem_address,
   input  logic [s_line-1:0] d_pmem_wdata,
   output logic [s_line-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_addr-1:0] pmem_address,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              arbiter_instr_state,
   output logic              arbiter_data_state,
   input  logic              clear_counters,
   output logic [s_cnt-1:0]  instr_wait_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_INSTR = 2'd1,
      S_DATA  = 2'd2
   } state_t;

   typedef enum logic {
      G_INSTR = 1'b0,
      G_DATA  = 1'b1
   } grant_t;

   localparam logic [s_cnt-1:0] cnt_one = 1;

   state_t state, state_next;
   grant_t last_grant, last_grant_next;
   logic   d_req;

   assign d_req        = d_pmem_read | d_pmem_write;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= G_INSTR;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_counters) begin
         instr_wait_count <= '0;
      end else if (i_pmem_read && (state != S_INSTR) && (instr_wait_count != '1)) begin
         instr_wait_count <= instr_wait_count + cnt_one;
      end
   end

   always_comb begin
      state_next          = state;
      last_grant_next     = last_grant;
      pmem_read           = 1'b0;
      pmem_write          = 1'b0;
      pmem_address        = '0;
      pmem_wdata          = '0;
      i_pmem_resp         = 1'b0;
      d_pmem_resp         = 1'b0;
      arbiter_instr_state = 1'b0;
      arbiter_data_state  = 1'b0;
      unique case (state)
         S_IDLE: begin
            // On contention the side that did not win last time goes first.
            if (i_pmem_read && d_req) begin
               state_next = (last_grant == G_INSTR) ? S_DATA : S_INSTR;
            end else if (i_pmem_read) begin
               state_next = S_INSTR;
            end else if (d_req) begin
               state_next = S_DATA;
            end
         end
         S_INSTR: begin
            arbiter_instr_state = 1'b1;
            pmem_read           = i_pmem_read;
            pmem_address        = i_pmem_address;
            i_pmem_resp         = pmem_resp;
            if (pmem_resp) begin
               state_next      = S_IDLE;
               last_grant_next = G_INSTR;
            end
         end
         S_DATA: begin
            arbiter_data_state = 1'b1;
            // A simultaneous read+write from d_cache is treated as a write.
            pmem_write         = d_pmem_write;
            pmem_read          = d_pmem_read & ~d_pmem_write;
            pmem_address       = d_pmem_address;
            pmem_wdata         = d_pmem_wdata;
            d_pmem_resp        = pmem_resp;
            if (pmem_resp) begin
               state_next      = S_IDLE;
               last_grant_next = G_DATA;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam longint unsigned CNT_MAX = 64'h0000_0000_FFFF_FFFF;
   localparam int SM_MAX = 15;

   logic         clk, rst;
   logic         i_pmem_read;
   logic [31:0]  i_pmem_address;
   logic [255:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read, d_pmem_write;
   logic [31:0]  d_pmem_address;
   logic [255:0] d_pmem_wdata, d_pmem_rdata;
   logic         d_pmem_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
   logic         arbiter_instr_state, arbiter_data_state;
   logic         clear_counters;
   logic [31:0]  instr_wait_count;

   logic [255:0] sm_i_rdata, sm_d_rdata, sm_wdata;
   logic         sm_i_resp, sm_d_resp, sm_read, sm_write, sm_is, sm_ds;
   logic [31:0]  sm_addr;
   logic [3:0]   sm_cnt;

   mem_port_arbiter #(.s_line(256), .s_addr(32), .s_cnt(32)) dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .arbiter_instr_state(arbiter_instr_state), .arbiter_data_state(arbiter_data_state),
      .clear_counters(clear_counters), .instr_wait_count(instr_wait_count)
   );

   // Narrow-counter instance so saturation is reachable in a short run.
   mem_port_arbiter #(.s_line(256), .s_addr(32), .s_cnt(4)) dut_sm (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(sm_i_rdata), .i_pmem_resp(sm_i_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(sm_d_rdata), .d_pmem_resp(sm_d_resp),
      .pmem_read(sm_read), .pmem_write(sm_write),
      .pmem_address(sm_addr), .pmem_wdata(sm_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .arbiter_instr_state(sm_is), .arbiter_data_state(sm_ds),
      .clear_counters(clear_counters), .instr_wait_count(sm_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Adaptor model: answers each strobe after resp_delay cycles with a one-cycle resp pulse.
   int           resp_delay = 4;
   int           late_count = 0;
   int           late_done;
   int           a_cnt;
   bit           ad_use_fixed = 0;
   logic [255:0] ad_fixed = '0;

   function automatic logic [255:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      pmem_resp  = 0;
      pmem_rdata = '0;
      a_cnt      = 0;
      late_done  = 0;
      forever begin
         @(posedge clk);
         #2;
         if (pmem_resp) begin
            pmem_resp = 0;
            a_cnt     = 0;
         end else if (late_count != late_done) begin
            late_done  = late_count;
            pmem_resp  = 1;
            pmem_rdata = rand_line();
         end else if (rst) begin
            a_cnt = 0;
         end else if (pmem_read || pmem_write) begin
            a_cnt++;
            if (a_cnt >= resp_delay) begin
               pmem_resp  = 1;
               pmem_rdata = ad_use_fixed ? ad_fixed : rand_line();
            end
         end else begin
            a_cnt = 0;
         end
      end
   end

   // Reference model: owner of the port (0 none, 1 instr, 2 data), last winner, stall counts.
   int              m_state, m_last, m_sm;
   longint unsigned m_cnt;
   logic            e_read, e_write, e_ir, e_dr, e_is, e_ds;
   logic [31:0]     e_addr;
   logic [255:0]    e_wdata;

   initial begin
      m_state = 0; m_last = 0; m_cnt = 0; m_sm = 0;
      forever begin
         @(negedge clk);
         e_read = 0; e_write = 0; e_ir = 0; e_dr = 0; e_is = 0; e_ds = 0;
         e_addr = '0; e_wdata = '0;
         if (m_state == 1) begin
            e_is = 1; e_read = i_pmem_read; e_addr = i_pmem_address; e_ir = pmem_resp;
         end else if (m_state == 2) begin
            e_ds = 1; e_write = d_pmem_write; e_read = d_pmem_read && !d_pmem_write;
            e_addr = d_pmem_address; e_wdata = d_pmem_wdata; e_dr = pmem_resp;
         end
         if (chk_en) begin
            check("pmem_read", 256'(pmem_read), 256'(e_read));
            check("pmem_write", 256'(pmem_write), 256'(e_write));
            check("pmem_address", 256'(pmem_address), 256'(e_addr));
            check("pmem_wdata", pmem_wdata, e_wdata);
            check("i_pmem_resp", 256'(i_pmem_resp), 256'(e_ir));
            check("d_pmem_resp", 256'(d_pmem_resp), 256'(e_dr));
            check("instr_state", 256'(arbiter_instr_state), 256'(e_is));
            check("data_state", 256'(arbiter_data_state), 256'(e_ds));
            check("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
            check("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
            check("wait_count", 256'(instr_wait_count), 256'(m_cnt));
            check("wait_count_sm", 256'(sm_cnt), 256'(m_sm));
         end
         if (rst) begin
            m_state = 0; m_last = 0; m_cnt = 0; m_sm = 0;
         end else begin
            if (clear_counters) begin
               m_cnt = 0; m_sm = 0;
            end else if (i_pmem_read && m_state != 1) begin
               if (m_cnt < CNT_MAX) m_cnt++;
               if (m_sm < SM_MAX) m_sm++;
            end
            if (m_state == 0) begin
               if (i_pmem_read && (d_pmem_read || d_pmem_write)) m_state = (m_last == 0) ? 2 : 1;
               else if (i_pmem_read) m_state = 1;
               else if (d_pmem_read || d_pmem_write) m_state = 2;
            end else if (pmem_resp) begin
               m_last  = (m_state == 1) ? 0 : 1;
               m_state = 0;
            end
         end
      end
   end

   // Samples taken at each negedge by the stimulus thread.
   logic         c_read, c_write, c_ir, c_dr, c_is, c_ds;
   logic [31:0]  c_addr, c_cnt;
   logic [255:0] c_wdata, c_irdat;
   logic [3:0]   c_smcnt;

   task automatic tick();
      @(negedge clk);
      c_read = pmem_read; c_write = pmem_write; c_addr = pmem_address; c_wdata = pmem_wdata;
      c_ir = i_pmem_resp; c_dr = d_pmem_resp; c_is = arbiter_instr_state;
      c_ds = arbiter_data_state; c_cnt = instr_wait_count; c_irdat = i_pmem_rdata;
      c_smcnt = sm_cnt;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input string name, input bit want_i, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!(want_i ? c_ir : c_dr) && cycles < 60);
      if (!(want_i ? c_ir : c_dr)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no resp after %0d cycles, required within 60", name, cycles);
      end
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   int    cyc;
   byte   grants[$];
   string exp_seq;
   bit    p_is, p_ds;

   initial begin
      rst = 1; clear_counters = 0;
      i_pmem_read = 0; i_pmem_address = '0;
      d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
      tick();
      chk_en = 1;
      tick();
      check("reset_instr_state", 256'(c_is), 256'(0));
      check("reset_count", 256'(c_cnt), 256'(0));
      rst = 0;

      // Lone instruction read, adaptor answers on the 4th cycle.
      resp_delay = 4; ad_use_fixed = 1; ad_fixed = {32{8'hAA}};
      i_pmem_read = 1; i_pmem_address = 32'h0000_0060;
      tick();
      check("t1_idle_read", 256'(c_read), 256'(0));
      tick();
      check("t1_grant_read", 256'(c_read), 256'(1));
      check("t1_grant_addr", 256'(c_addr), 256'(32'h60));
      wait_resp("t1_resp", 1, cyc);
      check("t1_latency", 256'(cyc), 256'(3));
      check("t1_rdata", c_irdat, {32{8'hAA}});
      i_pmem_read = 0;
      tick();
      check("t1_back_idle", 256'(c_is), 256'(0));
      check("t1_count", 256'(c_cnt), 256'(1));

      // Lone data writeback.
      resp_delay = 2;
      d_pmem_write = 1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = {32{8'h55}};
      tick();
      tick();
      check("t2_write", 256'(c_write), 256'(1));
      check("t2_addr", 256'(c_addr), 256'(32'h1000));
      check("t2_wdata", c_wdata, {32{8'h55}});
      wait_resp("t2_resp", 0, cyc);
      check("t2_no_iresp", 256'(c_ir), 256'(0));
      d_pmem_write = 0;
      tick();

      // Simultaneous requests right after reset: data first, then instr.
      do_reset();
      resp_delay = 3;
      i_pmem_read = 1; i_pmem_address = 32'h40;
      d_pmem_read = 1; d_pmem_address = 32'h2000;
      tick();
      tick();
      check("t3_data_first", 256'(c_ds), 256'(1));
      wait_resp("t3_dresp", 0, cyc);
      d_pmem_read = 0;
      tick();
      check("t3_gap_idle", 256'({c_is, c_ds}), 256'(0));
      tick();
      check("t3_instr_next", 256'(c_is), 256'(1));
      check("t3_count", 256'(c_cnt), 256'(5));
      wait_resp("t3_iresp", 1, cyc);
      i_pmem_read = 0;
      tick();

      // Sustained contention: both requests held high across six transactions.
      do_reset();
      resp_delay = 2;
      i_pmem_read = 1; i_pmem_address = 32'h100;
      d_pmem_read = 1; d_pmem_address = 32'h5000;
      p_is = 0; p_ds = 0;
      for (int k = 0; k < 100 && grants.size() < 6; k++) begin
         tick();
         if (c_ds && !p_ds) grants.push_back(8'h44);
         if (c_is && !p_is) grants.push_back(8'h49);
         p_is = c_is; p_ds = c_ds;
      end
      check("t4_grant_count", 256'(grants.size()), 256'(6));
      exp_seq = "DIDIDI";
      for (int k = 0; k < grants.size() && k < 6; k++)
         check($sformatf("t4_grant%0d", k), 256'(grants[k]), 256'(exp_seq[k]));
      wait_resp("t4_last_resp", c_is, cyc);
      i_pmem_read = 0; d_pmem_read = 0;
      tick();

      // Reset two cycles into a data read, then a stray adaptor resp.
      do_reset();
      resp_delay = 10;
      d_pmem_read = 1; d_pmem_address = 32'h3000;
      tick();
      tick();
      tick();
      check("t5_in_data", 256'(c_ds), 256'(1));
      rst = 1;
      tick();
      rst = 0; d_pmem_read = 0; late_count++;
      tick();
      check("t5_read_dropped", 256'(c_read), 256'(0));
      check("t5_idle", 256'(c_ds), 256'(0));
      check("t5_no_dresp", 256'(c_dr), 256'(0));
      check("t5_count", 256'(c_cnt), 256'(0));
      tick();

      // Counter clear while i_cache waits, then saturation of the narrow counter.
      do_reset();
      resp_delay = 30;
      d_pmem_read = 1; d_pmem_address = 32'h4000;
      tick();
      i_pmem_read = 1; i_pmem_address = 32'h80;
      for (int k = 0; k < 5; k++) tick();
      clear_counters = 1;
      tick();
      clear_counters = 0;
      tick();
      check("t6_cleared", 256'(c_cnt), 256'(0));
      tick();
      check("t6_resume", 256'(c_cnt), 256'(1));
      for (int k = 0; k < 16; k++) tick();
      check("t6_sat", 256'(c_smcnt), 256'(4'hF));
      tick();
      check("t6_sat_hold", 256'(c_smcnt), 256'(4'hF));
      wait_resp("t6_dresp", 0, cyc);
      d_pmem_read = 0;
      wait_resp("t6_iresp", 1, cyc);
      i_pmem_read = 0;
      tick();

      // Randomized traffic from both requesters.
      do_reset();
      ad_use_fixed = 0;
      for (int k = 0; k < 3000; k++) begin
         resp_delay     = $urandom_range(1, 5);
         clear_counters = ($urandom_range(0, 31) == 0);
         if (c_ir) begin
            i_pmem_read = 0;
         end else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
            i_pmem_read = 1; i_pmem_address = {$urandom()} & 32'hFFFF_FFE0;
         end
         if (c_dr) begin
            d_pmem_read = 0; d_pmem_write = 0;
         end else if (!d_pmem_read && !d_pmem_write && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
               0:       begin d_pmem_read = 1; d_pmem_write = 1; end
               1, 2, 3: d_pmem_write = 1;
               default: d_pmem_read = 1;
            endcase
            d_pmem_address = {$urandom()} & 32'hFFFF_FFE0;
            d_pmem_wdata   = rand_line();
         end
         tick();
      end
      clear_counters = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
